// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared constants, bus types and FSM encoding for the data memory responder
package data_ram_pkg;
  localparam int DataMemNumLog2 = 10;
  localparam int DataBusWidth = 32;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [DataBusWidth-1:0] ZeroWord = '0;
  typedef logic [3:0] byte_sel_t;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, RESP = 2'b10} state_t;
endpackage

// File: rtl/data_ram_if.sv
// data_ram_if: MEM-stage load/store bus; master drives req_i/we_i/addr_i/sel_i/wdata_i, slave drives ack_o/rdata_o/err_o
interface data_ram_if;
  import data_ram_pkg::*;
  logic req_i;
  logic we_i;
  logic [DataBusWidth-1:0] addr_i;
  byte_sel_t sel_i;
  logic [DataBusWidth-1:0] wdata_i;
  logic ack_o;
  logic [DataBusWidth-1:0] rdata_o;
  logic err_o;
  modport master (output req_i, we_i, addr_i, sel_i, wdata_i, input ack_o, rdata_o, err_o);
  modport slave (input req_i, we_i, addr_i, sel_i, wdata_i, output ack_o, rdata_o, err_o);
endinterface

// File: rtl/data_ram_bank.sv
// data_ram_bank: one byte lane of block RAM (clk; clr/re control the registered read port; we/addr/wdata write; rdata out)
module data_ram_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  logic [7:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk)
    if (clr) rdata <= 8'h00;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/data_ram.sv
// data_ram: single-port word memory behind a req/ack bus with wait states (clk, rst sync high, bus = data_ram_if.slave)
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DataMemNumLog2,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  data_ram_if.slave bus
);
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t state;
  logic [3:0] cnt;
  logic we_q;
  logic [DataBusWidth-1:0] addr_q, wdata_q;
  byte_sel_t sel_q;
  logic ack, err;
  logic cur_we, cur_err, go_resp;
  logic [DataBusWidth-1:0] cur_addr, cur_wdata;
  byte_sel_t cur_sel;
  logic [ADDR_WIDTH-1:0] idx;
  // With zero wait states the access completes on its capture edge, so the live bus is used in IDLE.
  always_comb begin
    cur_we = state == IDLE ? bus.we_i : we_q;
    cur_addr = state == IDLE ? bus.addr_i : addr_q;
    cur_sel = state == IDLE ? bus.sel_i : sel_q;
    cur_wdata = state == IDLE ? bus.wdata_i : wdata_q;
    cur_err = cur_addr[1:0] != 2'b00 || (cur_addr >> (ADDR_WIDTH + 2)) != ZeroWord || cur_sel == 4'b0000;
    idx = cur_addr[ADDR_WIDTH+1:2];
    go_resp = (state == IDLE && bus.req_i && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
  end
  always_ff @(posedge clk)
    if (rst == RstEnable) begin
      state <= IDLE;
      cnt <= 4'd0;
      we_q <= WriteDisable;
      addr_q <= ZeroWord;
      sel_q <= 4'b0000;
      wdata_q <= ZeroWord;
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= go_resp;
      if (go_resp) err <= cur_err;
      if (state == IDLE && bus.req_i) begin
        we_q <= bus.we_i;
        addr_q <= bus.addr_i;
        sel_q <= bus.sel_i;
        wdata_q <= bus.wdata_i;
        cnt <= WaitInit;
        state <= WAIT_CYCLES == 0 ? RESP : WAIT;
      end else if (state == WAIT) begin
        state <= cnt == 4'd0 ? RESP : WAIT;
        cnt <= cnt == 4'd0 ? cnt : cnt - 4'd1;
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  // Lane i carries bits 8i+7:8i, so sel[3] maps to bits 31:24 (big-endian lane 0).
  // The lane output registers are rdata_o: loaded only on the edge entering RESP, cleared on error or reset.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    data_ram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
      .clk   (clk),
      .clr   (rst == RstEnable || (go_resp && cur_err)),
      .re    (go_resp && cur_we == WriteDisable),
      .we    (rst != RstEnable && go_resp && cur_we == WriteEnable && !cur_err && cur_sel[i]),
      .addr  (idx),
      .wdata (cur_wdata[8*i+7:8*i]),
      .rdata (bus.rdata_o[8*i+7:8*i])
    );
  end
  assign bus.ack_o = ack;
  assign bus.err_o = err;
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: scoreboard bench for data_ram with one and zero wait states
module tb_data_ram;
  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
    logic        chk;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  data_ram_if ia();
  data_ram_if ib();
  data_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  data_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (ia.ack_o === 1'b1) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_ack: got ack expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("a_err", {31'd0, ia.err_o}, {31'd0, e.err});
        if (e.chk) chk("a_rdata", ia.rdata_o, e.rd);
      end
    end
  always @(negedge clk)
    if (ib.ack_o === 1'b1) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_ack: got ack expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("b_err", {31'd0, ib.err_o}, {31'd0, e.err});
        if (e.chk) chk("b_rdata", ib.rdata_o, e.rd);
      end
    end
  task automatic a_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    bit done;
    exp_t e;
    @(posedge clk);
    #1;
    ia.req_i = 1'b1;
    ia.we_i = we;
    ia.addr_i = addr;
    ia.sel_i = sel;
    ia.wdata_i = wd;
    e.cyc = cyc + 2;
    e.rd = exp_rd;
    e.err = exp_err;
    e.chk = !we;
    qa.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ia.ack_o === 1'b1) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL a_timeout: got no ack expected ack for addr %h", addr);
      void'(qa.pop_back());
    end
    ia.req_i = 1'b0;
  endtask
  initial begin
    exp_t e;
    int c;
    ia.req_i = 1'b0; ia.we_i = 1'b0; ia.addr_i = '0; ia.sel_i = '0; ia.wdata_i = '0;
    ib.req_i = 1'b0; ib.we_i = 1'b0; ib.addr_i = '0; ib.sel_i = '0; ib.wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_a_ack", {31'd0, ia.ack_o}, 32'd0);
      chk("idle_a_err", {31'd0, ia.err_o}, 32'd0);
      chk("idle_a_rdata", ia.rdata_o, 32'h0);
      chk("idle_b_ack", {31'd0, ib.ack_o}, 32'd0);
      chk("idle_b_err", {31'd0, ib.err_o}, 32'd0);
      chk("idle_b_rdata", ib.rdata_o, 32'h0);
    end
    a_access(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    a_access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    a_access(1'b1, 32'h10, 4'b0001, 32'h000000AA, 32'h0, 1'b0);
    a_access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEAA, 1'b0);
    a_access(1'b1, 32'h10, 4'b1000, 32'h11000000, 32'h0, 1'b0);
    a_access(1'b0, 32'h10, 4'b0001, 32'h0, 32'h11ADBEAA, 1'b0);
    a_access(1'b0, 32'h13, 4'b1111, 32'h0, 32'h0, 1'b1);
    a_access(1'b0, 32'h00001000, 4'b1111, 32'h0, 32'h0, 1'b1);
    a_access(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b1);
    a_access(1'b1, 32'h00001010, 4'b1111, 32'hFFFFFFFF, 32'h0, 1'b1);
    a_access(1'b0, 32'h10, 4'b1111, 32'h0, 32'h11ADBEAA, 1'b0);
    a_access(1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
    a_access(1'b0, 32'h20, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);
    @(posedge clk);
    #1;
    ia.req_i = 1'b1; ia.we_i = 1'b1; ia.addr_i = 32'h20; ia.sel_i = 4'b1111; ia.wdata_i = 32'h12345678;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ia.req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_a_ack", {31'd0, ia.ack_o}, 32'd0);
    chk("rst_a_err", {31'd0, ia.err_o}, 32'd0);
    chk("rst_a_rdata", ia.rdata_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_ack", {31'd0, ia.ack_o}, 32'd0);
    end
    a_access(1'b0, 32'h20, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);
    @(posedge clk);
    #1;
    c = cyc;
    e.cyc = c + 1; e.rd = 32'h0; e.err = 1'b0; e.chk = 1'b0;
    qb.push_back(e);
    e.cyc = c + 3; e.rd = 32'hA5A5A5A5; e.chk = 1'b1;
    qb.push_back(e);
    e.cyc = c + 5;
    qb.push_back(e);
    ib.req_i = 1'b1; ib.we_i = 1'b1; ib.addr_i = 32'h40; ib.sel_i = 4'b1111; ib.wdata_i = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    ib.wdata_i = 32'h0;
    @(posedge clk);
    #1;
    ib.we_i = 1'b0;
    @(posedge clk);
    #1;
    ib.we_i = 1'b1; ib.wdata_i = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    ib.we_i = 1'b0;
    @(posedge clk);
    #1;
    ib.req_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_ram.md
# data_ram

Single-port data memory responder at the far end of the MEM-stage load/store interface. Accepts one word-aligned read or write request at a time over a req/ack handshake. Applies big-endian byte-lane selects on writes and inserts a configurable number of wait states before acknowledging. Returns read data and an error flag to the MEM stage.

## Interface
- `ADDR_WIDTH`, 10: word-address width; capacity is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 1: wait states inserted between request capture and ack; legal range 0..15.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `req_i`  in  1  request valid from MEM stage
- `we_i`  in  1  1 = write, 0 = read
- `addr_i`  in  32  byte address
- `sel_i`  in  4  byte-lane enables; sel_i[3] selects bits 31:24 (big-endian lane 0)
- `wdata_i`  in  32  write data
- `ack_o`  out  1  one-cycle completion pulse
- `rdata_o`  out  32  read data; valid while ack_o is high
- `err_o`  out  1  misaligned or out-of-range access; valid while ack_o is high

## Operation
- FSM states:
  - IDLE: `req_i` high latches `we_i`, `addr_i`, `sel_i`, `wdata_i` into request registers. Next state is WAIT if `WAIT_CYCLES` > 0, else RESP.
  - WAIT: counter counts from `WAIT_CYCLES`-1 down to 0. At 0, next state is RESP.
  - RESP: `ack_o` = 1 for exactly one cycle, then IDLE.
- Inputs are ignored outside IDLE. The master holds them stable until ack and drops `req_i` in the ack cycle. A `req_i` still high in IDLE after ack starts a new access.
- Word index = addr[ADDR_WIDTH+1:2].
- Error conditions:
  - addr[1:0] != 0
  - addr[31:ADDR_WIDTH+2] != 0
  - `sel_i` == 0
- Error response: `err_o` = 1, no write, `rdata_o` = 0.
- Write: only lanes with `sel` = 1 are updated; other bytes are preserved.
- Read: returns the full word regardless of `sel`. The MEM stage extracts the byte or halfword.
- `rdata_o` and `err_o` are registered. They update only on the edge that enters RESP and hold their values otherwise.
- Memory contents are not reset.

## Timing
- Reset values: `ack_o` = 0, `rdata_o` = 0x00000000, `err_o` = 0, state IDLE, wait counter 0, request registers 0.
- Request sampled in cycle 0 → `ack_o` high in cycle `WAIT_CYCLES`+1.
  - `WAIT_CYCLES` = 0: ack in cycle 1.
  - `WAIT_CYCLES` = 1: ack in cycle 2.
- Write commit happens on the same edge that raises `ack_o`. It is never earlier, so an aborted access leaves memory untouched.
- Back-to-back throughput: one access per `WAIT_CYCLES`+2 cycles, because RESP→IDLE costs one cycle.
- `rst` during WAIT or RESP: next edge returns to IDLE with all outputs at reset values.
  - No ack is produced for the aborted request.
  - No write is committed if reset coincides with the commit edge; reset has priority.
- Read after write to the same word: the new data is returned, since the write commits before the later read's RESP.

## Structure
- Shared defines header additions:
  - `DataMemNumLog2` (default word-address width)
  - `ByteSelBus` (3:0)
  - `DataBusWidth`
- Reuse existing `RstEnable`, `ZeroWord`, `WriteEnable`, and `WriteDisable`.
- FSM state encodings are local parameters (IDLE=2'b00, WAIT=2'b01, RESP=2'b10).
- Sub-module `data_ram_bank`: 8-bit-wide, 2^ADDR_WIDTH-deep synchronous RAM with write enable, instantiated four times, one per byte lane, so synthesis infers block RAM.
- The top level holds the FSM, wait counter, request registers, error check and lane mapping.

## Test plan
- Reset, then idle for 5 cycles → `ack_o`, `err_o` stay 0 and `rdata_o` stays 0x00000000.
- `WAIT_CYCLES`=1: write 0xDEADBEEF to 0x10 with `sel`=4'b1111, then read 0x10 → each ack lands exactly 2 cycles after its request. Read returns 0xDEADBEEF with `err_o` = 0.
- Partial write 0x000000AA to 0x10 with `sel`=4'b0001, then read → 0xDEADBEAA. Then write 0x11000000 with `sel`=4'b1000, then read → 0x11ADBEAA.
- Read at 0x13 (misaligned) and at 0x00001000 with `ADDR_WIDTH`=10 (out of range) → `err_o` = 1 and `rdata_o` = 0 at ack. A following aligned read of 0x10 is unchanged.
- Write 0x12345678 to 0x20 and assert `rst` in the WAIT cycle → no ack. After reset, a read of 0x20 returns the prior contents, not 0x12345678.
- `WAIT_CYCLES`=0 with `req_i` held high for 3 accesses → ack in cycles 1, 3 and 5, and the inputs are ignored in the RESP cycles.
